// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct values, ALU control codes and the datapath mux select
// encodings used by both the controller and the datapath mux instances.
package mc_ctrl_pkg;

  // The PC-increment constant on ALUSrcB=01 is one word (word-addressed memory).
  localparam int INC_WORDS = 1;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_JAL     = 4'd10,
    S_JR      = 4'd11,
    S_ADDI_EX = 4'd12,
    S_ADDI_WB = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Datapath mux select encodings
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;

  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // True for the R-type functs that go through EXEC_R (jr excluded).
  function automatic logic is_alu_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  // True for every opcode/funct pair the controller can execute.
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_RTYPE:                                     return is_alu_funct(funct) || (funct == FN_JR);
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp request and the instruction funct field
// to the 3-bit ALU control code. Purely combinational.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  // Decode ALUOp first; only ALUOp=10 consults the funct field.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit (Moore FSM) driving every datapath select
// line and write strobe. Optional performance counters (RetireCnt,
// IllegalCnt) are built only when MC_CTRL_PERF_EN is defined.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUCtrl,
  output logic        InstrDone,
  output logic        IllegalOp
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] RetireCnt,
  output logic [15:0] IllegalCnt
`endif
);

  state_t     state;
  logic       pc_write_uncond;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       done_raw;
  logic       alu_active;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;

  mc_alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (Funct),
    .alu_ctrl (alu_dec)
  );

  // State register with synchronous reset; one state per clock.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE: begin
              if (Funct == FN_JR)          state <= S_JR;
              else if (is_alu_funct(Funct)) state <= S_EXEC_R;
              else                          state <= S_FETCH;
            end
            OP_BEQ:  state <= S_BEQ;
            OP_J:    state <= S_JUMP;
            OP_JAL:  state <= S_JAL;
            OP_ADDI: state <= S_ADDI_EX;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state <= S_MEMWB;
        S_EXEC_R:  state <= S_ALUWB;
        S_ADDI_EX: state <= S_ADDI_WB;
        // Final states and unreachable encodings all return to FETCH.
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode from the state register; strobes kept raw here
  // and qualified with reset below.
  always_comb begin
    IorD            = 1'b0;
    MemRead         = 1'b0;
    mem_write_raw   = 1'b0;
    ir_write_raw    = 1'b0;
    pc_write_uncond = 1'b0;
    branch          = 1'b0;
    reg_write_raw   = 1'b0;
    RegDst          = REGDST_RT;
    MemToReg        = M2R_ALUOUT;
    ALUSrcA         = 1'b0;
    ALUSrcB         = SRCB_B;
    PCSrc           = PCSRC_ALU;
    alu_active      = 1'b0;
    alu_op          = ALUOP_ADD;
    done_raw        = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead         = 1'b1;
        ir_write_raw    = 1'b1;
        ALUSrcB         = SRCB_INC;
        alu_active      = 1'b1;
        pc_write_uncond = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM;
        alu_active = 1'b1;
      end
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        alu_active = 1'b1;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemToReg      = M2R_MDR;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        alu_active = 1'b1;
        alu_op     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst        = REGDST_RD;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        alu_active = 1'b1;
        alu_op     = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        done_raw   = 1'b1;
      end
      S_JUMP: begin
        PCSrc           = PCSRC_JUMP;
        pc_write_uncond = 1'b1;
        done_raw        = 1'b1;
      end
      S_JAL: begin
        PCSrc           = PCSRC_JUMP;
        pc_write_uncond = 1'b1;
        RegDst          = REGDST_RA;
        MemToReg        = M2R_PC;
        reg_write_raw   = 1'b1;
        done_raw        = 1'b1;
      end
      S_JR: begin
        PCSrc           = PCSRC_REG;
        pc_write_uncond = 1'b1;
        done_raw        = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control is zero outside the states that use the ALU.
  assign ALUCtrl = alu_active ? alu_dec : 3'b000;

  // Write strobes and pulses are suppressed while reset is held so that an
  // abandoned instruction can never commit anything.
  assign PCWrite   = ~rst & (pc_write_uncond | (branch & Zero));
  assign IRWrite   = ~rst & ir_write_raw;
  assign RegWrite  = ~rst & reg_write_raw;
  assign MemWrite  = ~rst & mem_write_raw;
  assign InstrDone = ~rst & done_raw;
  assign IllegalOp = ~rst & (state == S_DECODE) & ~is_legal(Opcode, Funct);

`ifdef MC_CTRL_PERF_EN
  // Retired and illegal instruction counters, wrapping at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      RetireCnt  <= '0;
      IllegalCnt <= '0;
    end else begin
      if (InstrDone) RetireCnt  <= RetireCnt + 32'd1;
      if (IllegalOp) IllegalCnt <= IllegalCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard testbench for mc_controller. The driver pushes the expected
// control vector of every cycle of each instruction; a monitor pops and
// compares one vector per clock on the falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSrc;
  logic       ALUSrcA;
  logic [2:0] ALUCtrl;
  logic       InstrDone, IllegalOp;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] RetireCnt;
  logic [15:0] IllegalCnt;
`endif

  mc_controller dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtrl(ALUCtrl),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp)
`ifdef MC_CTRL_PERF_EN
    , .RetireCnt(RetireCnt), .IllegalCnt(IllegalCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       instr_done, illegal_op;
  } ctrl_t;

  typedef struct {
    ctrl_t v;
    string name;
  } exp_t;

  typedef enum int {
    K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR, K_EXEC_R, K_ALUWB,
    K_BEQ, K_JUMP, K_JAL, K_JR, K_ADDI_EX, K_ADDI_WB
  } kind_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_retire = 0;
  int   exp_illegal = 0;

  // Hand-written control vector of each state.
  function automatic ctrl_t exp_vec(input kind_t k, input logic [2:0] alu, input logic z);
    ctrl_t v = '0;
    case (k)
      K_FETCH: begin
        v.mem_read = 1; v.ir_write = 1; v.pc_write = 1;
        v.alu_src_b = 2'b01; v.alu_ctrl = 3'b010;
      end
      K_DECODE:  begin v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010; end
      K_MEMADR, K_ADDI_EX: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_ctrl = 3'b010; end
      K_MEMRD:   begin v.iord = 1; v.mem_read = 1; end
      K_MEMWB:   begin v.mem_to_reg = 2'b01; v.reg_write = 1; v.instr_done = 1; end
      K_MEMWR:   begin v.iord = 1; v.mem_write = 1; v.instr_done = 1; end
      K_EXEC_R:  begin v.alu_src_a = 1; v.alu_ctrl = alu; end
      K_ALUWB:   begin v.reg_dst = 2'b01; v.reg_write = 1; v.instr_done = 1; end
      K_BEQ: begin
        v.alu_src_a = 1; v.alu_ctrl = 3'b110; v.pc_src = 2'b01;
        v.pc_write = z; v.instr_done = 1;
      end
      K_JUMP:    begin v.pc_src = 2'b10; v.pc_write = 1; v.instr_done = 1; end
      K_JAL: begin
        v.pc_src = 2'b10; v.pc_write = 1; v.reg_dst = 2'b10;
        v.mem_to_reg = 2'b10; v.reg_write = 1; v.instr_done = 1;
      end
      K_JR:      begin v.pc_src = 2'b11; v.pc_write = 1; v.instr_done = 1; end
      K_ADDI_WB: begin v.reg_write = 1; v.instr_done = 1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(input kind_t k, input string nm, input logic [2:0] alu = 3'b000,
                      input logic z = 1'b0, input logic ill = 1'b0, input logic masked = 1'b0);
    exp_t e;
    e.v = exp_vec(k, alu, z);
    e.v.illegal_op = ill;
    if (masked) begin
      e.v.pc_write = 0; e.v.ir_write = 0; e.v.reg_write = 0;
      e.v.mem_write = 0; e.v.instr_done = 0; e.v.illegal_op = 0;
    end
    e.name = nm;
    expq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start an instruction in its FETCH cycle: drive the IR fields and push
  // the FETCH and DECODE expectations.
  task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string nm, input logic ill = 1'b0);
    Opcode = op; Funct = fn; Zero = z;
    push(K_FETCH, {nm, "/fetch"});
    push(K_DECODE, {nm, "/decode"}, 3'b000, 1'b0, ill);
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu, input string nm);
    start(6'b000000, fn, 1'b0, nm);
    push(K_EXEC_R, {nm, "/exec"}, alu);
    push(K_ALUWB, {nm, "/wb"});
    step(4);
    exp_retire++;
  endtask

  // Monitor: one expected vector per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t  e;
      ctrl_t a;
      e = expq.pop_front();
      a = '{IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, RegDst, MemToReg,
            ALUSrcA, ALUSrcB, PCSrc, ALUCtrl, InstrDone, IllegalOp};
      checks++;
      if (a !== e.v) begin
        failures++;
        $display("FAIL %s: got=%05h expected=%05h (t=%0t)", e.name, a, e.v, $time);
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  task automatic check_counters(input string nm);
    checks++;
    if (RetireCnt !== 32'(exp_retire) || IllegalCnt !== 16'(exp_illegal)) begin
      failures++;
      $display("FAIL %s: got retire=%0d illegal=%0d expected retire=%0d illegal=%0d",
               nm, RetireCnt, IllegalCnt, exp_retire, exp_illegal);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; Opcode = 6'b0; Funct = 6'b0; Zero = 1'b0;
    // Reset: FETCH selects visible, all strobes held low.
    step(1);
    push(K_FETCH, "reset1", 3'b000, 1'b0, 1'b0, 1'b1);
    step(1);
    push(K_FETCH, "reset2", 3'b000, 1'b0, 1'b0, 1'b1);
    step(1);
    rst = 1'b0;

    // lw: 5 cycles
    start(6'b100011, 6'b0, 1'b0, "lw");
    push(K_MEMADR, "lw/memadr", 3'b010);
    push(K_MEMRD,  "lw/memrd");
    push(K_MEMWB,  "lw/memwb");
    step(5); exp_retire++;

    // sw: 4 cycles
    start(6'b101011, 6'b0, 1'b0, "sw");
    push(K_MEMADR, "sw/memadr");
    push(K_MEMWR,  "sw/memwr");
    step(4); exp_retire++;

    // R-type ALU ops
    rtype(6'b101010, 3'b111, "slt");
    rtype(6'b100010, 3'b110, "sub");
    rtype(6'b100100, 3'b000, "and");
    rtype(6'b100101, 3'b001, "or");
    rtype(6'b100000, 3'b010, "add");

    // addi: 4 cycles
    start(6'b001000, 6'b0, 1'b0, "addi");
    push(K_ADDI_EX, "addi/ex");
    push(K_ADDI_WB, "addi/wb");
    step(4); exp_retire++;

    // beq taken and not taken
    start(6'b000100, 6'b0, 1'b1, "beq_taken");
    push(K_BEQ, "beq_taken/beq", 3'b000, 1'b1);
    step(3); exp_retire++;
    start(6'b000100, 6'b0, 1'b0, "beq_not");
    push(K_BEQ, "beq_not/beq", 3'b000, 1'b0);
    step(3); exp_retire++;

    // j, jal, jr
    start(6'b000010, 6'b0, 1'b0, "j");
    push(K_JUMP, "j/jump");
    step(3); exp_retire++;
    start(6'b000011, 6'b0, 1'b0, "jal");
    push(K_JAL, "jal/jal");
    step(3); exp_retire++;
    start(6'b000000, 6'b001000, 1'b0, "jr");
    push(K_JR, "jr/jr");
    step(3); exp_retire++;

    // Illegal opcode and illegal R-type funct: 2 cycles each
    start(6'b111111, 6'b0, 1'b0, "ill_op", 1'b1);
    step(2); exp_illegal++;
    start(6'b000000, 6'b000001, 1'b0, "ill_fn", 1'b1);
    step(2); exp_illegal++;

`ifdef MC_CTRL_PERF_EN
    check_counters("counters_run");
`endif

    // Reset asserted during MEMWR of sw: no write, FETCH follows.
    start(6'b101011, 6'b0, 1'b0, "sw_rst");
    push(K_MEMADR, "sw_rst/memadr");
    push(K_MEMWR,  "sw_rst/memwr", 3'b000, 1'b0, 1'b0, 1'b1);
    push(K_FETCH,  "sw_rst/fetch_in_rst", 3'b000, 1'b0, 1'b0, 1'b1);
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_retire = 0; exp_illegal = 0;

    // 3 legal + 1 illegal after reset
    start(6'b100011, 6'b0, 1'b0, "lw2");
    push(K_MEMADR, "lw2/memadr");
    push(K_MEMRD,  "lw2/memrd");
    push(K_MEMWB,  "lw2/memwb");
    step(5); exp_retire++;
    start(6'b000010, 6'b0, 1'b0, "j2");
    push(K_JUMP, "j2/jump");
    step(3); exp_retire++;
    start(6'b001000, 6'b0, 1'b0, "addi2");
    push(K_ADDI_EX, "addi2/ex");
    push(K_ADDI_WB, "addi2/wb");
    step(4); exp_retire++;
    start(6'b111111, 6'b0, 1'b0, "ill2", 1'b1);
    step(2); exp_illegal++;

`ifdef MC_CTRL_PERF_EN
    check_counters("counters_3_1");
`endif

    // Every expected vector must have been consumed.
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
